config_packet_assembler: RTL and testbench
==========================================

# config_packet_assembler

Upstream stage of the neuron memory controller: the config-side network interface (NI). It receives fixed-width flits from the router's local port and assembles them into configuration packets of PACKET_SIZE bits. Completed packets are buffered in a small FIFO. The memory controller drains the FIFO through an empty/read handshake with a registered read port.

## Interface
- FLIT_WIDTH, 16: router flit width.
- PACKET_SIZE, 44: assembled packet width ({parameter_code[3:0], neuron_id[7:0], 32-bit payload}).
- FLITS_PER_PACKET, 3: flits per packet. Must satisfy FLITS_PER_PACKET*FLIT_WIDTH >= PACKET_SIZE.
- FIFO_DEPTH, 4: packet FIFO entries. Power of two, >= 2.
- CNT_WIDTH, 3: width of fifo_count_o. Equal to clog2(FIFO_DEPTH+1).

Ports:
- clk_i, input, 1: single clock. All state updates on its rising edge.
- reset_i, input, 1: synchronous, active-high reset.
- flit_i, input, FLIT_WIDTH: incoming flit.
- flit_valid_i, input, 1: flit_i is valid this cycle.
- flit_ready_o, output, 1: block can accept a flit this cycle.
- abort_i, input, 1: discard the partially assembled packet.
- read_i, input, 1: pop the FIFO head (the memory controller's read_NI).
- packet_o, output, PACKET_SIZE: registered read data.
- empty_o, output, 1: FIFO holds no complete packet (the memory controller's NI_empty).
- full_o, output, 1: FIFO holds FIFO_DEPTH packets.
- fifo_count_o, output, CNT_WIDTH: number of buffered packets.
- err_o, output, 1: sticky underflow flag. Cleared only by reset.

## Operation
- A flit is accepted on a rising edge when flit_valid_i && flit_ready_o.
- Assembly state is flit_cnt, 0..FLITS_PER_PACKET-1, plus an assembly shift register.
  - Flits arrive MSB-first.
  - Each accepted flit shifts in at the LSB end: asm <= {asm, flit_i}.
  - flit_cnt increments on every accepted flit and wraps to 0 after the last flit.
- Completion: on acceptance of flit number FLITS_PER_PACKET-1, the packet is written to the FIFO tail.
  - Packet value = top PACKET_SIZE bits of {flit0, flit1, ..., flit_last}.
  - The low (FLITS_PER_PACKET*FLIT_WIDTH - PACKET_SIZE) bits of the last flit are discarded.
- flit_ready_o = !(flit_cnt == FLITS_PER_PACKET-1 && full_o). This is combinational from state only and has no dependence on read_i.
  - Non-final flits are always accepted, even when the FIFO is full.
- abort_i:
  - Clears flit_cnt to 0 and drops any partial packet.
  - Has priority over a flit accepted in the same cycle; that flit is dropped.
  - FIFO contents are untouched.
- Read: read_i with !empty_o loads packet_o with the FIFO head and advances the read pointer.
  - read_i with empty_o has no effect on the pointers. packet_o holds its value and err_o is set.
- Simultaneous push and pop:
  - Both happen in the same edge and fifo_count_o is unchanged.
  - When empty, a push and a read in the same cycle counts as underflow: the read is ignored and the push proceeds.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_count_o is tracked by a separate counter: +1 on push only, -1 on pop only.
- empty_o = (count == 0) and full_o = (count == FIFO_DEPTH). Both are decoded from the registered count.

## Timing
- Reset values:
  - flit_cnt = 0 and pointers = 0.
  - packet_o = 0, empty_o = 1, full_o = 0, fifo_count_o = 0, err_o = 0, flit_ready_o = 1.
  - FIFO storage need not be reset.
- Reset mid-packet discards the partial packet and all buffered packets. The first flit after reset is treated as flit 0.
- Flit-to-FIFO latency: empty_o falls on the edge after the final flit is accepted, i.e. 1 cycle.
- Read latency: packet_o is valid in the cycle after the cycle in which read_i was sampled high. This matches the memory controller registering read_NI into its write enable.
- Back-to-back reads on consecutive cycles deliver consecutive packets on consecutive cycles.
- Sustained throughput: one packet per FLITS_PER_PACKET cycles with read_i held high.
- Full FIFO with final flit pending: flit_ready_o is low. It returns high the cycle after a pop lowers the count.

## Test plan
- Basic assembly: with defaults, flits 0xA123, 0x4567, 0x89B0 on 3 consecutive cycles -> empty_o falls after the 3rd edge. Then pulse read_i -> packet_o = 44'hA123456789B the next cycle, and empty_o returns to 1.
- Fill and backpressure: 4 packets with no reads -> full_o = 1 and fifo_count_o = 4.
  - The next 2 flits are accepted; on the 3rd, flit_ready_o = 0.
  - One read -> flit_ready_o = 1 next cycle, and the stalled flit completes packet 5.
  - Draining returns packets in order 1..5.
- Simultaneous push/pop: count = 2, final flit accepted in the same cycle as read_i -> count stays 2 and packet_o = oldest packet.
- Abort: accept 2 flits, then assert abort_i together with a valid flit -> that flit is dropped. The next 3 flits form one packet and fifo_count_o increases by exactly 1.
- Underflow: read_i while empty -> err_o = 1 and stays 1, packet_o unchanged, count stays 0. Only reset_i clears err_o.
- Reset mid-operation: 2 packets buffered plus 1 partial flit, then reset_i for 1 cycle -> all outputs at reset values. The next 3 flits produce a correctly aligned packet.

Source files
------------

// File: rtl/config_packet_assembler.sv
// config_packet_assembler: config-side NI that packs router flits into packets
// and buffers them in a small FIFO drained through an empty/read handshake.
// Ports: clk_i, reset_i (sync, active high); flit_i/flit_valid_i/flit_ready_o
// flit intake; abort_i drops the partial packet; read_i pops the FIFO head into
// registered packet_o; empty_o/full_o/fifo_count_o report FIFO occupancy;
// err_o is a sticky underflow flag. Needs FLITS_PER_PACKET >= 2 and a
// power-of-two FIFO_DEPTH >= 2.
module config_packet_assembler #(
  parameter int FLIT_WIDTH       = 16,
  parameter int PACKET_SIZE      = 44,
  parameter int FLITS_PER_PACKET = 3,
  parameter int FIFO_DEPTH       = 4,
  parameter int CNT_WIDTH        = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [FLIT_WIDTH-1:0]  flit_i,
  input  logic                   flit_valid_i,
  output logic                   flit_ready_o,
  input  logic                   abort_i,
  input  logic                   read_i,
  output logic [PACKET_SIZE-1:0] packet_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [CNT_WIDTH-1:0]   fifo_count_o,
  output logic                   err_o
);

  localparam int ASM_W  = FLITS_PER_PACKET * FLIT_WIDTH;
  localparam int HIST_W = ASM_W - FLIT_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FC_W   = $clog2(FLITS_PER_PACKET);

  localparam logic [FC_W-1:0]      LAST  = FC_W'(FLITS_PER_PACKET - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(FIFO_DEPTH);

  logic [FC_W-1:0]        flit_cnt;
  logic [HIST_W-1:0]      hist_q;
  logic [ASM_W-1:0]       asm_d;
  logic [PACKET_SIZE-1:0] pkt_w;

  logic [PACKET_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_WIDTH-1:0]   count;

  logic last_flit;
  logic accept;
  logic push;
  logic pop;

  assign last_flit    = (flit_cnt == LAST);
  assign flit_ready_o = !(last_flit && full_o);
  assign accept       = flit_valid_i && flit_ready_o;
  assign push         = accept && last_flit && !abort_i && !reset_i;
  assign pop          = read_i && !empty_o;

  // Earlier flits sit in hist_q; the packet is the MSB end of the
  // full flit sequence, so trailing bits of the last flit fall off.
  assign asm_d = {hist_q, flit_i};
  assign pkt_w = asm_d[ASM_W-1 -: PACKET_SIZE];

  assign empty_o      = (count == '0);
  assign full_o       = (count == DEPTH);
  assign fifo_count_o = count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flit_cnt <= '0;
      hist_q   <= '0;
    end else if (abort_i) begin
      flit_cnt <= '0;
    end else if (accept) begin
      hist_q   <= asm_d[HIST_W-1:0];
      flit_cnt <= last_flit ? '0 : flit_cnt + FC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= pkt_w;
    end
  end

  // A read against an empty FIFO is an underflow even if a push
  // lands on the same edge; the push still goes through.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      packet_o <= '0;
      err_o    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        packet_o <= mem[rd_ptr];
      end
      if (read_i && empty_o) begin
        err_o <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_config_packet_assembler.sv
// tb_config_packet_assembler: directed bench for config_packet_assembler.
// Table of per-cycle vectors plus hand sequences for FIFO corner cases.
module tb_config_packet_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] flit = '0;
  logic        flit_valid = 1'b0;
  logic        flit_ready;
  logic        abort = 1'b0;
  logic        read = 1'b0;
  logic [43:0] packet;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  config_packet_assembler dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .flit_i       (flit),
    .flit_valid_i (flit_valid),
    .flit_ready_o (flit_ready),
    .abort_i      (abort),
    .read_i       (read),
    .packet_o     (packet),
    .empty_o      (empty),
    .full_o       (full),
    .fifo_count_o (count),
    .err_o        (err)
  );

  typedef struct {
    logic        v;
    logic [15:0] f;
    logic        ab;
    logic        rd;
    logic [43:0] pkt;
    logic        e;
    logic        fu;
    logic [2:0]  c;
    logic        er;
    logic        r;
  } vec_t;

  vec_t vq[$];
  logic [43:0] exq[$];

  function automatic vec_t mv(logic v, logic [15:0] f, logic ab,
                              logic rd, logic [43:0] pkt, logic e,
                              logic fu, logic [2:0] c, logic er,
                              logic r);
    vec_t t;
    t.v = v; t.f = f; t.ab = ab; t.rd = rd; t.pkt = pkt;
    t.e = e; t.fu = fu; t.c = c; t.er = er; t.r = r;
    return t;
  endfunction

  function automatic logic [15:0] fl(int p, int j);
    return {4'(p), 4'(j), 8'(p * 7 + j * 13 + 3)};
  endfunction

  function automatic logic [43:0] mk(int p);
    logic [47:0] w;
    w = {fl(p, 0), fl(p, 1), fl(p, 2)};
    return w[47:4];
  endfunction

  function automatic logic [6:0] st(logic e, logic fu, logic [2:0] c,
                                    logic er, logic r);
    return {e, fu, c, er, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic [6:0] exp);
    chk(nm, 64'({empty, full, count, err, flit_ready}), 64'(exp));
  endtask

  task automatic cyc(input logic v, input logic [15:0] f,
                     input logic ab, input logic rd);
    flit_valid = v;
    flit = f;
    abort = ab;
    read = rd;
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
    abort = 1'b0;
    read = 1'b0;
  endtask

  task automatic rst(input string nm);
    reset = 1'b1;
    flit_valid = 1'b0;
    abort = 1'b0;
    read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk({nm, " pkt"}, 64'(packet), 64'd0);
    chk_st({nm, " st"}, st(1, 0, 0, 0, 1));
  endtask

  task automatic send_pkt(input int p);
    for (int j = 0; j < 3; j++) cyc(1, fl(p, j), 0, 0);
    exq.push_back(mk(p));
  endtask

  initial begin
    logic [43:0] p1;
    logic [43:0] p2;
    logic [43:0] p3;
    logic [43:0] e;
    p1 = 44'hA123456789B;
    p2 = 44'h44445555666;
    p3 = 44'h77778888999;

    vq.push_back(mv(1, 16'hA123, 0, 0, 44'h0, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h4567, 0, 0, 44'h0, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h89B0, 0, 0, 44'h0, 0, 0, 1, 0, 1));
    vq.push_back(mv(0, 16'h0000, 0, 1, p1, 1, 0, 0, 0, 1));
    vq.push_back(mv(0, 16'h0000, 0, 0, p1, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h1111, 0, 0, p1, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h2222, 0, 0, p1, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h3333, 1, 0, p1, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h4444, 0, 0, p1, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h5555, 0, 0, p1, 1, 0, 0, 0, 1));
    vq.push_back(mv(1, 16'h6666, 0, 0, p1, 0, 0, 1, 0, 1));
    vq.push_back(mv(0, 16'h0000, 0, 1, p2, 1, 0, 0, 0, 1));
    vq.push_back(mv(0, 16'h0000, 0, 1, p2, 1, 0, 0, 1, 1));
    vq.push_back(mv(0, 16'h0000, 0, 0, p2, 1, 0, 0, 1, 1));
    vq.push_back(mv(1, 16'h7777, 0, 0, p2, 1, 0, 0, 1, 1));
    vq.push_back(mv(1, 16'h8888, 0, 0, p2, 1, 0, 0, 1, 1));
    vq.push_back(mv(1, 16'h9999, 0, 1, p2, 0, 0, 1, 1, 1));
    vq.push_back(mv(0, 16'h0000, 0, 1, p3, 1, 0, 0, 1, 1));

    @(posedge clk);
    rst("reset0");

    foreach (vq[i]) begin
      cyc(vq[i].v, vq[i].f, vq[i].ab, vq[i].rd);
      chk($sformatf("vec%0d pkt", i), 64'(packet), 64'(vq[i].pkt));
      chk_st($sformatf("vec%0d st", i),
             st(vq[i].e, vq[i].fu, vq[i].c, vq[i].er, vq[i].r));
    end

    rst("reset1");

    for (int p = 1; p <= 4; p++) send_pkt(p);
    chk_st("fill4", st(0, 1, 4, 0, 1));
    cyc(1, fl(5, 0), 0, 0);
    cyc(1, fl(5, 1), 0, 0);
    chk_st("bp ready low", st(0, 1, 4, 0, 0));
    cyc(1, fl(5, 2), 0, 0);
    chk_st("bp stalled", st(0, 1, 4, 0, 0));
    cyc(1, fl(5, 2), 0, 1);
    e = exq.pop_front();
    chk("bp pop pkt", 64'(packet), 64'(e));
    chk_st("bp pop st", st(0, 0, 3, 0, 1));
    cyc(1, fl(5, 2), 0, 0);
    exq.push_back(mk(5));
    chk_st("bp pkt5 in", st(0, 1, 4, 0, 1));
    for (int k = 0; k < 4; k++) begin
      cyc(0, 16'h0, 0, 1);
      e = exq.pop_front();
      chk($sformatf("drain%0d pkt", k + 2), 64'(packet), 64'(e));
    end
    chk_st("drained", st(1, 0, 0, 0, 1));

    send_pkt(6);
    send_pkt(7);
    cyc(1, fl(8, 0), 0, 0);
    cyc(1, fl(8, 1), 0, 0);
    chk_st("pp before", st(0, 0, 2, 0, 1));
    cyc(1, fl(8, 2), 0, 1);
    exq.push_back(mk(8));
    e = exq.pop_front();
    chk("pp pkt", 64'(packet), 64'(e));
    chk_st("pp st", st(0, 0, 2, 0, 1));
    for (int k = 0; k < 2; k++) begin
      cyc(0, 16'h0, 0, 1);
      e = exq.pop_front();
      chk($sformatf("pp drain%0d", k), 64'(packet), 64'(e));
    end
    chk_st("pp drained", st(1, 0, 0, 0, 1));

    send_pkt(9);
    send_pkt(10);
    cyc(1, fl(11, 0), 0, 0);
    chk_st("pre reset", st(0, 0, 2, 0, 1));
    exq.delete();
    rst("reset mid");
    send_pkt(12);
    chk_st("post reset push", st(0, 0, 1, 0, 1));
    cyc(0, 16'h0, 0, 1);
    e = exq.pop_front();
    chk("post reset pkt", 64'(packet), 64'(e));
    chk_st("post reset st", st(1, 0, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
